cmp_result_tracker: RTL and testbench

//   Sequential consumer placed directly downstream of the 2-bit magnitude comparator.

---
 rtl/cmp_result_tracker.sv | 74 +++++++
 tb/tb_cmp_result_tracker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker: counts magnitude-comparator outcomes, detects equal runs, latches non-one-hot samples
module cmp_result_tracker #(
  parameter int CNT_W  = 8,
  parameter int EQ_RUN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             f1,
  input  logic             f2,
  input  logic             f3,
  input  logic             clr,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [3:0]       run_len,
  output logic             hit,
  output logic             hit_pulse,
  output logic             err,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LOCK = 2'd2, ERR = 2'd3} state_t;
  localparam logic [3:0] RUN_MAX = 4'(EQ_RUN);
  state_t           r_state, w_state_nx;
  logic [3:0]       r_run, w_run_nx;
  logic             r_pulse, w_pulse_nx;
  logic [CNT_W-1:0] r_gt, r_eq, r_lt;
  logic             w_oh, w_act, w_take;
  // odd parity excluding 111 leaves exactly the one-hot patterns
  assign w_oh   = (f1 ^ f2 ^ f3) & ~(f1 & f2 & f3);
  assign w_act  = in_valid & (r_state != ERR);
  assign w_take = w_act & w_oh;
  always_comb begin
    w_state_nx = r_state;
    w_run_nx   = r_run;
    w_pulse_nx = 1'b0;
    if (w_act && !w_oh) begin
      w_state_nx = ERR;
      w_run_nx   = '0;
    end else if (w_take && !f2) begin
      w_state_nx = IDLE;
      w_run_nx   = '0;
    end else if (w_take && r_state != LOCK) begin
      w_run_nx   = r_run + 4'd1;
      w_state_nx = (w_run_nx == RUN_MAX) ? LOCK : RUN;
      w_pulse_nx = w_run_nx == RUN_MAX;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= IDLE;
      r_run   <= '0;
      r_pulse <= 1'b0;
      r_gt    <= '0;
      r_eq    <= '0;
      r_lt    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= w_run_nx;
      r_pulse <= w_pulse_nx;
      if (w_take && f1 && r_gt != '1) r_gt <= r_gt + CNT_W'(1);
      if (w_take && f2 && r_eq != '1) r_eq <= r_eq + CNT_W'(1);
      if (w_take && f3 && r_lt != '1) r_lt <= r_lt + CNT_W'(1);
    end
  end
  assign gt_cnt    = r_gt;
  assign eq_cnt    = r_eq;
  assign lt_cnt    = r_lt;
  assign run_len   = r_run;
  assign hit       = r_state == LOCK;
  assign hit_pulse = r_pulse;
  assign err       = r_state == ERR;
  assign state     = r_state;
endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb_cmp_result_tracker: directed vector table, saturation sequence and random run against a counting model
module tb_cmp_result_tracker;
  localparam int EQ_RUN = 3;
  logic       clk = 1'b0, rst = 1'b0, clr = 1'b0, in_valid = 1'b0, f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
  logic [7:0] gt_cnt, eq_cnt, lt_cnt;
  logic [3:0] run_len, s_run;
  logic       hit, hit_pulse, err, s_hit, s_pulse, s_err;
  logic [1:0] state, s_state, s_gt, s_eq, s_lt;
  int         n_cmp = 0, n_bad = 0;
  int         m_gt[2], m_eq[2], m_lt[2], m_run, m_st;
  bit         m_err, m_pulse, m_hit;
  always #5 clk = ~clk;
  cmp_result_tracker #(.CNT_W(8), .EQ_RUN(EQ_RUN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .f1(f1), .f2(f2), .f3(f3), .clr(clr),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .run_len(run_len),
    .hit(hit), .hit_pulse(hit_pulse), .err(err), .state(state));
  cmp_result_tracker #(.CNT_W(2), .EQ_RUN(EQ_RUN)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .f1(f1), .f2(f2), .f3(f3), .clr(clr),
    .gt_cnt(s_gt), .eq_cnt(s_eq), .lt_cnt(s_lt), .run_len(s_run),
    .hit(s_hit), .hit_pulse(s_pulse), .err(s_err), .state(s_state));
  typedef struct {
    bit r, c, v;
    logic [2:0] f;
    int gt, eq, lt, run;
    bit hit, pulse, err;
    int st;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int sat(int x, int cap);
    return x < cap ? x + 1 : cap;
  endfunction
  task automatic model(bit r, bit c, bit v, logic [2:0] f);
    m_pulse = 0;
    if (r || c) begin
      m_gt = '{0, 0}; m_eq = '{0, 0}; m_lt = '{0, 0}; m_run = 0; m_err = 0;
    end else if (v && !m_err) begin
      if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) begin
        m_err = 1; m_run = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (f == 3'b100) m_gt[k] = sat(m_gt[k], k == 0 ? 255 : 3);
          if (f == 3'b010) m_eq[k] = sat(m_eq[k], k == 0 ? 255 : 3);
          if (f == 3'b001) m_lt[k] = sat(m_lt[k], k == 0 ? 255 : 3);
        end
        if (f == 3'b010) begin
          m_pulse = m_run == EQ_RUN - 1;
          m_run = sat(m_run, EQ_RUN);
        end else m_run = 0;
      end
    end
    m_hit = m_run == EQ_RUN;
    m_st = m_err ? 3 : m_hit ? 2 : m_run > 0 ? 1 : 0;
  endtask
  task automatic step(bit r, bit c, bit v, logic [2:0] f);
    rst = r; clr = c; in_valid = v; {f1, f2, f3} = f;
    @(posedge clk); #1;
    model(r, c, v, f);
    chk("model_w8", {gt_cnt, eq_cnt, lt_cnt, run_len, hit, hit_pulse, err, state},
        {8'(m_gt[0]), 8'(m_eq[0]), 8'(m_lt[0]), 4'(m_run), m_hit, m_pulse, m_err, 2'(m_st)});
    chk("model_w2", {s_gt, s_eq, s_lt, s_run, s_hit, s_pulse, s_err, s_state},
        {2'(m_gt[1]), 2'(m_eq[1]), 2'(m_lt[1]), 4'(m_run), m_hit, m_pulse, m_err, 2'(m_st)});
  endtask
  task automatic add(bit r, bit c, bit v, logic [2:0] f, int gt, int eq, int lt, int run,
                     bit h, bit p, bit e, int st);
    vec_t x;
    x.r = r; x.c = c; x.v = v; x.f = f; x.gt = gt; x.eq = eq; x.lt = lt; x.run = run;
    x.hit = h; x.pulse = p; x.err = e; x.st = st;
    tbl.push_back(x);
  endtask
  initial begin
    // r c v f      gt eq lt run hit pulse err st
    add(0,0,1,3'b100, 1,0,0,0, 0,0,0,0);
    add(0,0,1,3'b010, 1,1,0,1, 0,0,0,1);
    add(0,0,1,3'b001, 1,1,1,0, 0,0,0,0);
    add(0,0,1,3'b100, 2,1,1,0, 0,0,0,0);
    add(0,1,1,3'b010, 0,0,0,0, 0,0,0,0);
    add(0,0,1,3'b010, 0,1,0,1, 0,0,0,1);
    add(0,0,1,3'b010, 0,2,0,2, 0,0,0,1);
    add(0,0,0,3'b111, 0,2,0,2, 0,0,0,1);
    add(0,0,0,3'b000, 0,2,0,2, 0,0,0,1);
    add(0,0,1,3'b010, 0,3,0,3, 1,1,0,2);
    add(0,0,1,3'b010, 0,4,0,3, 1,0,0,2);
    add(0,0,1,3'b001, 0,4,1,0, 0,0,0,0);
    add(0,1,0,3'b000, 0,0,0,0, 0,0,0,0);
    add(0,0,1,3'b010, 0,1,0,1, 0,0,0,1);
    add(0,0,1,3'b010, 0,2,0,2, 0,0,0,1);
    add(0,0,1,3'b100, 1,2,0,0, 0,0,0,0);
    add(0,0,1,3'b010, 1,3,0,1, 0,0,0,1);
    add(0,1,0,3'b000, 0,0,0,0, 0,0,0,0);
    add(0,0,1,3'b010, 0,1,0,1, 0,0,0,1);
    add(0,0,1,3'b110, 0,1,0,0, 0,0,1,3);
    add(0,0,1,3'b100, 0,1,0,0, 0,0,1,3);
    add(0,1,1,3'b100, 0,0,0,0, 0,0,0,0);
    add(0,0,1,3'b010, 0,1,0,1, 0,0,0,1);
    add(0,0,1,3'b010, 0,2,0,2, 0,0,0,1);
    add(0,0,1,3'b010, 0,3,0,3, 1,1,0,2);
    add(0,0,1,3'b000, 0,3,0,0, 0,0,1,3);
    add(0,0,1,3'b010, 0,3,0,0, 0,0,1,3);
    add(1,1,1,3'b010, 0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 2; i++) begin
      step(1, 1'($urandom), 1'($urandom), 3'($urandom));
      chk("reset", {gt_cnt, eq_cnt, lt_cnt, run_len, hit, hit_pulse, err, state}, 33'd0);
    end
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].f);
      chk($sformatf("vec%0d", i), {gt_cnt, eq_cnt, lt_cnt, run_len, hit, hit_pulse, err, state},
          {8'(tbl[i].gt), 8'(tbl[i].eq), 8'(tbl[i].lt), 4'(tbl[i].run), tbl[i].hit, tbl[i].pulse,
           tbl[i].err, 2'(tbl[i].st)});
    end
    step(0, 1, 0, 3'b000);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 3'b001);
      chk($sformatf("sat_lt%0d", i), 64'(s_lt), 64'(i < 3 ? i : 3));
      chk("sat_other", {s_gt, s_eq}, 4'd0);
    end
    step(1, 1, 1, 3'b001);
    chk("sat_rst_clr", {s_gt, s_eq, s_lt, s_run, s_hit, s_pulse, s_err, s_state}, 15'd0);
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [2:0] f;
      sel = $urandom_range(0, 19);
      f = sel == 0 ? 3'($urandom) : sel < 10 ? 3'b010 : sel < 15 ? 3'b100 : 3'b001;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, f);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
